// File: rtl/present_perm_engine_if.sv
// rtl/present_perm_engine_if.sv - input/output handshake bundle for the PRESENT permutation engine
interface present_perm_engine_if #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_inv;
    logic [CNT_W-1:0] in_count;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_inv, in_count, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_inv, in_count, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/present_perm_engine.sv
// rtl/present_perm_engine.sv - iterative PRESENT-style bit permutation, forward or inverse, count times
module present_perm_engine #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    present_perm_engine_if.slave   bus
);
    localparam int Q     = WIDTH / 4;
    localparam int M     = WIDTH - 1;
    localparam int IDX_W = $clog2(WIDTH);

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
            $error("present_perm_engine: WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             inv_q,   inv_d;
    logic             in_ready_w;
    logic             accept_w;

    // Bit M is a fixed point in both directions; 4*Q == M+1 makes the two maps mutual inverses.
    function automatic logic [WIDTH-1:0] perm(input logic [WIDTH-1:0] x, input logic inv);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < M; i++) begin
            if (inv)
                r[IDX_W'((4 * i) % M)] = x[IDX_W'(i)];
            else
                r[IDX_W'((i * Q) % M)] = x[IDX_W'(i)];
        end
        r[M] = x[M];
        return r;
    endfunction

    assign in_ready_w    = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
    assign accept_w      = bus.in_valid && in_ready_w;
    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_data  = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            inv_q   <= inv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // A load in DONE replaces the held result with no idle cycle in between.
                if (accept_w) begin
                    data_d  = bus.in_data;
                    inv_d   = bus.in_inv;
                    cnt_d   = bus.in_count;
                    state_d = (bus.in_count == '0) ? S_DONE : S_RUN;
                end else if (state_q == S_DONE && bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                data_d = perm(data_q, inv_q);
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1))
                    state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_present_perm_engine.sv
// tb/tb_present_perm_engine.sv - self-checking bench for present_perm_engine
module tb_present_perm_engine;
    localparam int W  = 64;
    localparam int CW = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    present_perm_engine_if #(.WIDTH(W), .CNT_W(CW)) bus ();
    present_perm_engine #(.WIDTH(W), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [63:0] d;
        bit          inv;
        int          cnt;
        logic [63:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: move every bit to its destination index by shift arithmetic, repeated count times.
    function automatic logic [63:0] model(input logic [63:0] x, input bit inv, input int count);
        logic [63:0] cur;
        logic [63:0] nxt;
        int q;
        int m;
        int dst;
        cur = x;
        q = W / 4;
        m = W - 1;
        for (int r = 0; r < count; r++) begin
            nxt = cur & (64'h1 << m);
            for (int i = 0; i < m; i++) begin
                dst = inv ? (4 * i) % m : (i * q) % m;
                nxt = nxt | (((cur >> i) & 64'h1) << dst);
            end
            cur = nxt;
        end
        return cur;
    endfunction

    task automatic run_txn(input logic [63:0] d, input bit inv, input int count,
                           input logic [63:0] exp, input string name);
        int edges;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_inv    = inv;
        bus.in_count  = CW'(count);
        bus.out_ready = 1'b1;
        chk({name, " in_ready"}, 64'(bus.in_ready), 64'h1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        edges = 1;
        while (!bus.out_valid && edges <= 64) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk({name, " latency"}, 64'(edges), 64'(count + 1));
        chk({name, " data"}, bus.out_data, exp);
        @(posedge clk);
        #1;
        chk({name, " released"}, 64'(bus.out_valid), 64'h0);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!bus.out_valid && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.out_valid) chk({name, " timeout"}, 64'(bus.out_valid), 64'h1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] mid;
        logic [63:0] rd;
        bit          rinv;
        int          rcnt;

        vecs[0] = '{64'h2,                   1'b0, 1,  64'h0000_0000_0001_0000, "v_bit1_fwd"};
        vecs[1] = '{64'h0000_0000_0001_0000, 1'b1, 1,  64'h2,                   "v_bit16_inv"};
        vecs[2] = '{64'h8000_0000_0000_0001, 1'b0, 1,  64'h8000_0000_0000_0001, "v_fixed_pts"};
        vecs[3] = '{64'h0123_4567_89AB_CDEF, 1'b0, 3,  64'h0123_4567_89AB_CDEF, "v_order3_fwd"};
        vecs[4] = '{64'h0123_4567_89AB_CDEF, 1'b0, 0,  64'h0123_4567_89AB_CDEF, "v_count0"};
        vecs[5] = '{64'h0123_4567_89AB_CDEF, 1'b1, 3,  64'h0123_4567_89AB_CDEF, "v_order3_inv"};
        vecs[6] = '{64'h10,                  1'b0, 1,  64'h2,                   "v_bit4_fwd"};
        vecs[7] = '{64'h2,                   1'b0, 31, 64'h0000_0000_0001_0000, "v_count_max"};
        vecs[8] = '{64'h2,                   1'b1, 2,  64'h0000_0000_0001_0000, "v_inv2"};
        vecs[9] = '{64'h0,                   1'b1, 5,  64'h0,                   "v_zero"};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_inv    = 1'b0;
        bus.in_count  = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset out_valid", 64'(bus.out_valid), 64'h0);
        chk("reset out_data", bus.out_data, 64'h0);
        chk("reset in_ready", 64'(bus.in_ready), 64'h1);

        for (int k = 0; k < 10; k++)
            run_txn(vecs[k].d, vecs[k].inv, vecs[k].cnt, vecs[k].exp, vecs[k].name);

        mid = model(64'h0123_4567_89AB_CDEF, 1'b0, 2);
        run_txn(64'h0123_4567_89AB_CDEF, 1'b0, 2, mid, "chain_fwd2");
        run_txn(mid, 1'b1, 2, 64'h0123_4567_89AB_CDEF, "chain_inv2");

        // Backpressure in DONE, then a back-to-back load on release.
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'h2;
        bus.in_inv    = 1'b0;
        bus.in_count  = CW'(1);
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_valid("bp");
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("bp out_valid", 64'(bus.out_valid), 64'h1);
            chk("bp out_data", bus.out_data, 64'h0000_0000_0001_0000);
            chk("bp in_ready", 64'(bus.in_ready), 64'h0);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'h0123_4567_89AB_CDEF;
        bus.in_count  = CW'(0);
        #1;
        chk("b2b in_ready", 64'(bus.in_ready), 64'h1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("b2b out_valid", 64'(bus.out_valid), 64'h1);
        chk("b2b out_data", bus.out_data, 64'h0123_4567_89AB_CDEF);
        @(posedge clk);
        #1;
        chk("b2b released", 64'(bus.out_valid), 64'h0);

        // Inputs presented during RUN must be ignored.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h10;
        bus.in_inv   = 1'b0;
        bus.in_count = CW'(4);
        @(posedge clk);
        #1;
        bus.in_data  = 64'hFFFF_0000_FFFF_0000;
        bus.in_count = CW'(0);
        chk("run in_ready", 64'(bus.in_ready), 64'h0);
        @(posedge clk);
        #1;
        chk("run in_ready 2", 64'(bus.in_ready), 64'h0);
        bus.in_valid = 1'b0;
        wait_valid("run_ignore");
        chk("run_ignore data", bus.out_data, 64'h2);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a long run.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h0123_4567_89AB_CDEF;
        bus.in_inv   = 1'b0;
        bus.in_count = CW'(20);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_run out_valid", 64'(bus.out_valid), 64'h0);
        rst = 1'b1;
        #1;
        chk("rst out_valid", 64'(bus.out_valid), 64'h0);
        chk("rst out_data", bus.out_data, 64'h0);
        chk("rst in_ready", 64'(bus.in_ready), 64'h1);
        @(negedge clk);
        rst = 1'b0;
        run_txn(64'h0123_4567_89AB_CDEF, 1'b0, 20, model(64'h0123_4567_89AB_CDEF, 1'b0, 20), "post_rst");

        for (int k = 0; k < 40; k++) begin
            rd   = {$urandom, $urandom};
            rinv = 1'($urandom_range(0, 1));
            rcnt = int'($urandom_range(0, 31));
            run_txn(rd, rinv, rcnt, model(rd, rinv, rcnt), $sformatf("rand%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
